// File: rtl/bcd_serial_adder_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : bcd_serial_adder_ctrl
// Description : Digit-serial multi-digit BCD adder controller. One single-digit
//               BCD add/correct stage is reused over DIGITS packed-BCD digit
//               pairs, least significant digit first. The decimal carry passes
//               from one digit to the next through a register.
// Ports       : clk     - clock, rising edge
//               rst_n   - asynchronous active-low reset
//               start   - request pulse, accepted in IDLE or DONE
//               a, b    - packed BCD operands (digit i = [4i+3:4i])
//               cin     - decimal carry-in to digit 0
//               busy    - operation in progress
//               done    - one-cycle completion pulse
//               sum     - packed BCD result, held until next completion
//               cout    - decimal carry-out of the top digit
//               invalid - an operand digit was >9 in the last operation
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_serial_adder_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  invalid
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    res_q;
    logic            carry_q;
    logic            inv_q;
    logic [CW-1:0]   cnt_q;

    // One-digit add/correct stage: the only arithmetic in the design.
    logic [4:0]      t_d;
    logic            gt9_d;
    logic [3:0]      digit_d;
    logic [W-1:0]    res_d;
    logic            inv_d;

    always_comb begin
        t_d     = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0000, carry_q};
        gt9_d   = (t_d > 5'd9);
        // +6 skips the six unused codes; the top bit is the decimal carry.
        digit_d = gt9_d ? 4'(t_d + 5'd6) : t_d[3:0];
        // New digit enters at the MS end so digit 0 ends up at the LS end.
        res_d   = {digit_d, res_q[W-1:4]};
        inv_d   = inv_q | (a_q[3:0] > 4'd9) | (b_q[3:0] > 4'd9);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            inv_q   <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            invalid <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        inv_q   <= 1'b0;
                        busy    <= 1'b1;
                        state_q <= S_ADD;
                    end else begin
                        busy    <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_ADD: begin
                    res_q   <= res_d;
                    a_q     <= {4'b0000, a_q[W-1:4]};
                    b_q     <= {4'b0000, b_q[W-1:4]};
                    carry_q <= gt9_d;
                    inv_q   <= inv_d;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == CW'(DIGITS - 1)) begin
                        // Last digit: publish the freshly shifted result.
                        sum     <= res_d;
                        cout    <= gt9_d;
                        invalid <= inv_d;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_serial_adder_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_bcd_serial_adder_ctrl
// Description : Self-checking bench for bcd_serial_adder_ctrl with a DIGITS=4
//               instance and a DIGITS=2 instance. The expected results come
//               from a digit-by-digit decimal reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_serial_adder_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start = 1'b0, cin = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        busy, done, cout, invalid;
    logic [15:0] sum;

    logic        start2 = 1'b0, cin2 = 1'b0;
    logic [7:0]  a2 = '0, b2 = '0;
    logic        busy2, done2, cout2, invalid2;
    logic [7:0]  sum2;

    int tests = 0;
    int errs  = 0;

    always #5 clk = ~clk;

    bcd_serial_adder_ctrl #(.DIGITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .invalid(invalid)
    );

    bcd_serial_adder_ctrl #(.DIGITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .invalid(invalid2)
    );

    // Reference: decimal column addition, one digit at a time.
    function automatic void model(input logic [63:0] av, input logic [63:0] bv,
                                  input logic ci, input int n,
                                  output logic [63:0] s, output logic co,
                                  output logic inv);
        int c;
        c   = int'(ci);
        s   = '0;
        inv = 1'b0;
        for (int i = 0; i < n; i++) begin
            int da, db, t, d;
            da = int'((av >> (4 * i)) & 64'hF);
            db = int'((bv >> (4 * i)) & 64'hF);
            if (da > 9 || db > 9) inv = 1'b1;
            t = da + db + c;
            if (t > 9) begin d = (t + 6) % 16; c = 1; end
            else       begin d = t;            c = 0; end
            s = s | (64'(d) << (4 * i));
        end
        co = (c != 0);
    endfunction

    // One DIGITS=4 operation; returns at the sample point of the done cycle.
    task automatic do_op(input logic [15:0] av, input logic [15:0] bv,
                         input logic ci, input string name);
        logic [63:0] es;
        logic        ec, ei;
        int          lat;
        logic        bad;
        model({48'h0, av}, {48'h0, bv}, ci, 4, es, ec, ei);
        @(negedge clk);
        a = av; b = bv; cin = ci; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        lat = 0; bad = 1'b0;
        while (!done && lat < 20) begin
            if (!busy) bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        tests++;
        if (lat != 4 || bad || busy !== 1'b0) begin
            errs++;
            $display("FAIL %s timing: latency %0d busy_gap %0b busy_at_done %0b, required latency 4 busy_gap 0 busy_at_done 0",
                     name, lat, bad, busy);
        end
        tests++;
        if (sum !== es[15:0] || cout !== ec || invalid !== ei) begin
            errs++;
            $display("FAIL %s result: sum %h cout %0b inv %0b, required sum %h cout %0b inv %0b",
                     name, sum, cout, invalid, es[15:0], ec, ei);
        end
    endtask

    task automatic test_reset;
        #2;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 16'h0 || cout !== 1'b0 || invalid !== 1'b0) begin
            errs++;
            $display("FAIL reset_state: busy %b done %b sum %h cout %b inv %b, required all 0",
                     busy, done, sum, cout, invalid);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        do_op(16'h1234, 16'h5678, 1'b0, "basic_1234_5678");
        repeat (2) @(posedge clk);
        do_op(16'h9999, 16'h0001, 1'b0, "ripple_9999_0001");
        do_op(16'h0000, 16'h0000, 1'b1, "cin_only");
        do_op(16'h00A0, 16'h0005, 1'b0, "invalid_00A0_0005");
        // A valid operation right after must clear the sticky flag.
        do_op(16'h0101, 16'h0202, 1'b0, "invalid_cleared");
        // Outputs hold after the pulse.
        @(posedge clk); #1;
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || sum !== 16'h0303) begin
            errs++;
            $display("FAIL hold_after_done: done %b busy %b sum %h, required 0 0 0303", done, busy, sum);
        end
    endtask

    task automatic test_random;
        for (int k = 0; k < 40; k++) begin
            logic [15:0] av, bv;
            for (int i = 0; i < 4; i++) begin
                av[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
                bv[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            do_op(av, bv, 1'($urandom), "random");
        end
    endtask

    task automatic test_start_ignored;
        int lat, ndone, nbusy;
        repeat (3) @(posedge clk);
        @(negedge clk);
        a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;            // E0
        start = 1'b0;
        @(posedge clk); #1;            // second ADD cycle
        a = 16'h1111; b = 16'h1111; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 2;
        while (!done && lat < 20) begin @(posedge clk); #1; lat++; end
        tests++;
        if (lat != 4 || sum !== 16'h6912 || cout !== 1'b0) begin
            errs++;
            $display("FAIL start_ignored: latency %0d sum %h cout %b, required 4 6912 0", lat, sum, cout);
        end
        ndone = 0; nbusy = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
            if (busy) nbusy++;
        end
        tests++;
        if (ndone != 0 || nbusy != 0) begin
            errs++;
            $display("FAIL start_ignored_extra: dones %0d busy_cycles %0d, required 0 0", ndone, nbusy);
        end
    endtask

    task automatic test_back_to_back;
        do_op(16'h1234, 16'h5678, 1'b0, "b2b_first");
        // do_op drives start during this DONE cycle.
        do_op(16'h5000, 16'h5000, 1'b0, "b2b_5000_5000");
        do_op(16'h9999, 16'h9999, 1'b1, "b2b_9999_9999_c1");
    endtask

    task automatic test_digits2;
        int lat;
        logic [63:0] es;
        logic ec, ei;
        for (int k = 0; k < 6; k++) begin
            logic [7:0] av, bv;
            logic ci;
            if (k == 0) begin av = 8'h45; bv = 8'h67; ci = 1'b0; end
            else begin
                av = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                bv = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                ci = 1'($urandom);
            end
            model({56'h0, av}, {56'h0, bv}, ci, 2, es, ec, ei);
            @(negedge clk);
            a2 = av; b2 = bv; cin2 = ci; start2 = 1'b1;
            @(posedge clk); #1;
            start2 = 1'b0;
            lat = 0;
            while (!done2 && lat < 20) begin @(posedge clk); #1; lat++; end
            tests++;
            if (lat != 2 || busy2 !== 1'b0 || sum2 !== es[7:0] || cout2 !== ec || invalid2 !== ei) begin
                errs++;
                $display("FAIL digits2_%0d: latency %0d sum %h cout %b inv %b, required 2 %h %b %b",
                         k, lat, sum2, cout2, invalid2, es[7:0], ec, ei);
            end
        end
    endtask

    task automatic test_reset_mid;
        int ndone;
        repeat (2) @(posedge clk);
        @(negedge clk);
        a = 16'h4321; b = 16'h1234; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;            // E0
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;            // third ADD cycle
        rst_n = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 16'h0 || cout !== 1'b0 || invalid !== 1'b0) begin
            errs++;
            $display("FAIL reset_mid: busy %b done %b sum %h cout %b inv %b, required all 0",
                     busy, done, sum, cout, invalid);
        end
        ndone = 0;
        for (int i = 0; i < 4; i++) begin @(posedge clk); #1; if (done) ndone++; end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin @(posedge clk); #1; if (done || busy) ndone++; end
        tests++;
        if (ndone != 0) begin
            errs++;
            $display("FAIL reset_mid_no_done: activity cycles %0d, required 0", ndone);
        end
        do_op(16'h2468, 16'h1357, 1'b1, "after_reset");
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_start_ignored;
        test_back_to_back;
        test_digits2;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
